// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
interface bit_serial_adder_if #(
    parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic             clear;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, clear, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, clear, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/fulladder.sv
// Single-bit full adder used as the serial datapath slice.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// Adds two WIDTH-bit operands one bit per clock, LSB first.
//   state | meaning
//   IDLE  | waiting for start; last result held on sum/cout/overflow
//   RUN   | adding bit cnt of the captured operands
//   DONE  | one-cycle result-valid pulse, then back to IDLE
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    bit_serial_adder_if.slave   bus
);
    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               fa_s;
    logic               fa_co;

    fulladder u_fa (
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.clear) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt] <= fa_s;
                    carry      <= fa_co;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the top bit here
                        cout_q <= fa_co;
                        ovf_q  <= carry ^ fa_co;
                        cnt    <= '0;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == RUN) || (state == DONE);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized and directed checks of bit_serial_adder against an arithmetic model.
module tb_bit_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sum"},  64'(bus.sum), 64'd0);
        chk({tag, "_cout"}, 64'(bus.cout), 64'd0);
        chk({tag, "_ovf"},  64'(bus.overflow), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    // One full operation; noisy drives start with junk operands while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input bit noisy);
        logic [W:0] full;
        logic       ovf;
        int         dones = 0;
        int         busys = 0;
        full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = ci; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy) busys++;
            if (bus.done) dones++;
            chk("done_timing", 64'(bus.done), 64'(i == 8));
            if (i == 8 || i == 9) begin
                chk("sum",  64'(bus.sum), 64'(full[W-1:0]));
                chk("cout", 64'(bus.cout), 64'(full[W]));
                chk("ovf",  64'(bus.overflow), 64'(ovf));
            end
            if (i == 9) chk("idle_busy", 64'(bus.busy), 64'd0);
            if (noisy && (i inside {2, 3, 4, 8})) begin
                bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'hAA;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("busy_cycles", 64'(busys), 64'd9);
        chk("done_count",  64'(dones), 64'd1);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.clear = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #1;
        chk_zero("reset");
        #16 rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h0F, 8'h01, 1'b0, 1'b1);

        // asynchronous reset while bit 4 is pending
        @(negedge clk);
        bus.a = 8'h55; bus.b = 8'h33; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        #3 rst_n = 1'b1;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("post_reset_activity", 64'(dones), 64'd0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0);

        // clear beats start while running
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_clear_sum_nonzero", 64'(bus.sum != '0), 64'd1);
        bus.clear = 1'b1; bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'hAA;
        @(negedge clk);
        chk_zero("clear");
        bus.clear = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("clear_no_accept", 64'(bus.busy), 64'd0);

        run_op(8'h01, 8'h01, 1'b0, 1'b0);
        run_op(8'h02, 8'h02, 1'b0, 1'b0);

        repeat (40) run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
